// File: rtl/slot_spin_controller_pkg.sv
// Shared types and constants for the slot machine spin controller.
package slot_pkg;

  typedef enum logic [2:0] {IDLE, SPIN, STOPPING, EVAL, SHOW} spin_state_t;

  localparam int REEL_COUNT = 3;
  localparam int SYM_W      = 4;
  localparam int CREDIT_W   = 7;
  localparam int CREDIT_MAX = 99;

  // Add in 8 bits so the clamp sees the true sum before truncation.
  function automatic logic [CREDIT_W-1:0] credit_add(input logic [CREDIT_W-1:0] c,
                                                      input logic [7:0] amt);
    logic [7:0] sum;
    sum = {1'b0, c} + amt;
    return (sum > 8'(CREDIT_MAX)) ? CREDIT_W'(CREDIT_MAX) : sum[CREDIT_W-1:0];
  endfunction

endpackage

// File: rtl/slot_spin_controller_if.sv
// Controller <-> button/reel/display signal bundle.
interface slot_spin_if;
  import slot_pkg::*;

  logic                  start_but;
  logic [SYM_W-1:0]      reel_num0;
  logic [SYM_W-1:0]      reel_num1;
  logic [SYM_W-1:0]      reel_num2;
  logic [REEL_COUNT-1:0] reel_run;
  logic                  busy;
  logic                  win;
  logic                  blink;
  logic [CREDIT_W-1:0]   credits;
  logic                  no_credit;

  modport master (
    input  start_but, reel_num0, reel_num1, reel_num2,
    output reel_run, busy, win, blink, credits, no_credit
  );

  modport slave (
    output start_but, reel_num0, reel_num1, reel_num2,
    input  reel_run, busy, win, blink, credits, no_credit
  );
endinterface

// File: rtl/slot_spin_controller_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks.
module slot_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/slot_spin_controller.sv
// One play of the three-reel slot: spin, staggered stop, evaluate, win display.
// Optional pair payout is built when SLOT_PAIR_PAYOUT_EN is defined.
module slot_spin_controller
  import slot_pkg::*;
#(
  parameter int TICK_DIV     = 50000,
  parameter int MIN_SPIN     = 500,
  parameter int AUTO_STOP    = 3000,
  parameter int STOP_GAP     = 300,
  parameter int FLASH_TICKS  = 2000,
  parameter int BLINK_TICKS  = 250,
  parameter int CREDITS_INIT = 10,
  parameter int WIN_PAYOUT   = 20
`ifdef SLOT_PAIR_PAYOUT_EN
  , parameter int PAIR_PAYOUT = 2
`endif
) (
  input  logic            clk,
  input  logic            rst,
  slot_spin_if.master     bus
);
  localparam int T_MAX = (AUTO_STOP > FLASH_TICKS) ? AUTO_STOP : FLASH_TICKS;
  localparam int T_TOP = (T_MAX > 2*STOP_GAP + 1) ? T_MAX : 2*STOP_GAP + 1;
  localparam int TMR_W = $clog2(T_TOP + 1);
  localparam int BLK_W = $clog2(BLINK_TICKS + 1);

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_q;
  logic       rst_n;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_q <= '0;
    else      rst_q <= {rst_q[0], 1'b1};
  end
  assign rst_n = rst_q[1];

  logic tick;
  slot_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst_n), .tick(tick));

  logic [2:0] sync_q;
  logic       press;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], bus.start_but};
  end
  assign press = sync_q[1] & ~sync_q[2];

  spin_state_t           state_q, state_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [BLK_W-1:0]      bcnt_q, bcnt_d;
  logic                  blink_q, blink_d;
  logic [REEL_COUNT-1:0] reel_q, reel_d;
  logic [CREDIT_W-1:0]   credits_q, credits_d;
  logic                  no_credit_q, no_credit_d;
  logic                  all_eq;
`ifdef SLOT_PAIR_PAYOUT_EN
  logic                  any_eq;
`endif

  assign all_eq = (bus.reel_num0 == bus.reel_num1) && (bus.reel_num1 == bus.reel_num2);
`ifdef SLOT_PAIR_PAYOUT_EN
  assign any_eq = (bus.reel_num0 == bus.reel_num1) || (bus.reel_num1 == bus.reel_num2) ||
                  (bus.reel_num0 == bus.reel_num2);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      bcnt_q      <= '0;
      blink_q     <= 1'b1;
      reel_q      <= '0;
      credits_q   <= CREDIT_W'(CREDITS_INIT);
      no_credit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bcnt_q      <= bcnt_d;
      blink_q     <= blink_d;
      reel_q      <= reel_d;
      credits_q   <= credits_d;
      no_credit_q <= no_credit_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = tick ? timer_q + TMR_W'(1) : timer_q;
    bcnt_d      = bcnt_q;
    blink_d     = blink_q;
    reel_d      = reel_q;
    credits_d   = credits_q;
    no_credit_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (press) begin
          if (credits_q != '0) begin
            state_d   = SPIN;
            timer_d   = '0;
            reel_d    = '1;
            credits_d = credits_q - CREDIT_W'(1);
          end else begin
            no_credit_d = 1'b1;
          end
        end
      end
      SPIN: begin
        if ((press && timer_q >= TMR_W'(MIN_SPIN)) ||
            (tick && timer_q == TMR_W'(AUTO_STOP - 1))) begin
          state_d   = STOPPING;
          timer_d   = '0;
          reel_d[0] = 1'b0;
        end
      end
      STOPPING: begin
        if (tick) begin
          if (timer_q == TMR_W'(STOP_GAP - 1))     reel_d[1] = 1'b0;
          if (timer_q == TMR_W'(2*STOP_GAP - 1))   reel_d[2] = 1'b0;
          if (timer_q == TMR_W'(2*STOP_GAP))       state_d   = EVAL;
        end
      end
      EVAL: begin
        state_d = IDLE;
        if (all_eq) begin
          state_d   = SHOW;
          timer_d   = '0;
          bcnt_d    = '0;
          blink_d   = 1'b0;
          credits_d = credit_add(credits_q, 8'(WIN_PAYOUT));
        end
`ifdef SLOT_PAIR_PAYOUT_EN
        else if (any_eq) begin
          credits_d = credit_add(credits_q, 8'(PAIR_PAYOUT));
        end
`endif
      end
      SHOW: begin
        // A press here only ends the display; it never starts a new spin.
        if (press || (tick && timer_q == TMR_W'(FLASH_TICKS - 1))) begin
          state_d = IDLE;
        end else if (tick) begin
          if (bcnt_q == BLK_W'(BLINK_TICKS - 1)) begin
            bcnt_d  = '0;
            blink_d = ~blink_q;
          end else begin
            bcnt_d  = bcnt_q + BLK_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.reel_run  = reel_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.win       = (state_q == SHOW);
  assign bus.blink     = (state_q != SHOW) | blink_q;
  assign bus.credits   = credits_q;
  assign bus.no_credit = no_credit_q;
endmodule

// File: tb/tb_slot_spin_controller.sv
// Directed self-checking bench for slot_spin_controller with short timing parameters.
module tb_slot_spin_controller;
  import slot_pkg::*;

  localparam int TD = 4, MS = 2, AS = 10, SG = 3, FT = 8, BT = 2, CI = 3, WP = 10;
`ifdef SLOT_PAIR_PAYOUT_EN
  localparam int PP = 2;
`else
  localparam int PP = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0, passes = 0, cyc = 0, tk = 0;

  slot_spin_if bus();

  slot_spin_controller #(
    .TICK_DIV(TD), .MIN_SPIN(MS), .AUTO_STOP(AS), .STOP_GAP(SG),
    .FLASH_TICKS(FT), .BLINK_TICKS(BT), .CREDITS_INIT(CI), .WIN_PAYOUT(WP)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Edges since reset release; the two-flop reset release delays the prescaler by two clocks.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  function automatic bit tick_edge(input int n);
    return (n >= TD + 2) && ((n - 2) % TD == 0);
  endfunction

  task automatic step();
    @(posedge clk); #1;
    if (tick_edge(cyc)) tk++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.start_but = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tk = 0;
  endtask

  task automatic set_reels(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    bus.reel_num0 = a; bus.reel_num1 = b; bus.reel_num2 = c;
  endtask

  task automatic press();
    bus.start_but = 1'b1;
    repeat (3) step();
    bus.start_but = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    int t0, g;
    t0 = tk; g = 0;
    while (tk - t0 < n && g < 1000) begin step(); g++; end
  endtask

  // Full play: start, early stop, wait for result, leave the win display by press.
  task automatic play(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    int g;
    set_reels(a, b, c);
    press();
    wait_ticks(MS + 1);
    press();
    g = 0;
    while (bus.busy && !bus.win && g < 400) begin step(); g++; end
    if (g >= 400) begin checks++; $display("FAIL play_timeout busy=%b win=%b", bus.busy, bus.win); end
    if (bus.win) press();
    repeat (4) step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.reel_run !== 3'b000) $display("FAIL rst_reel_run got=%b exp=000", bus.reel_run); else passes++;
    checks++; if (bus.win !== 1'b0) $display("FAIL rst_win got=%b exp=0", bus.win); else passes++;
    checks++; if (bus.blink !== 1'b1) $display("FAIL rst_blink got=%b exp=1", bus.blink); else passes++;
    checks++; if (bus.credits !== 7'd3) $display("FAIL rst_credits got=%0d exp=3", bus.credits); else passes++;
    checks++; if (bus.no_credit !== 1'b0) $display("FAIL rst_no_credit got=%b exp=0", bus.no_credit); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", bus.busy); else passes++;
  endtask

  task automatic test_auto_stop();
    int t0, t, n;
    logic [2:0] exp;
    do_reset();
    set_reels(4'd1, 4'd2, 4'd3);
    repeat (2) step();
    bus.start_but = 1'b1;
    step(); step();
    checks++; if (bus.reel_run !== 3'b000) $display("FAIL press_early got=%b exp=000", bus.reel_run); else passes++;
    step();
    checks++; if (bus.reel_run !== 3'b111) $display("FAIL press_run got=%b exp=111", bus.reel_run); else passes++;
    checks++; if (bus.credits !== 7'd2) $display("FAIL press_credits got=%0d exp=2", bus.credits); else passes++;
    checks++; if (bus.busy !== 1'b1) $display("FAIL press_busy got=%b exp=1", bus.busy); else passes++;
    // Button stays held well past MIN_SPIN: a level-sensitive press would stop the reels early.
    t0 = tk; n = 0;
    while (n < 400) begin
      step(); n++;
      if (n == 20) bus.start_but = 1'b0;
      t = tk - t0;
      if (t >= AS + 2*SG + 1) break;
      exp = (t < AS) ? 3'b111 : (t < AS + SG) ? 3'b110 : (t < AS + 2*SG) ? 3'b100 : 3'b000;
      checks++; if (bus.reel_run !== exp) $display("FAIL auto_reel tick=%0d got=%b exp=%b", t, bus.reel_run, exp); else passes++;
      checks++; if (bus.win !== 1'b0) $display("FAIL auto_win tick=%0d got=%b exp=0", t, bus.win); else passes++;
    end
    if (n >= 400) begin checks++; $display("FAIL auto_timeout ticks=%0d", tk - t0); end
    checks++; if (bus.busy !== 1'b1) $display("FAIL eval_busy got=%b exp=1", bus.busy); else passes++;
    step();
    checks++; if (bus.busy !== 1'b0) $display("FAIL lose_idle got=%b exp=0", bus.busy); else passes++;
    checks++; if (bus.win !== 1'b0) $display("FAIL lose_win got=%b exp=0", bus.win); else passes++;
    checks++; if (bus.credits !== 7'd2) $display("FAIL lose_credits got=%0d exp=2", bus.credits); else passes++;
  endtask

  task automatic test_min_spin();
    int t0, t, n, pc;
    bit pressed;
    logic [2:0] exp;
    do_reset();
    set_reels(4'd1, 4'd2, 4'd3);
    press();
    t0 = tk;
    wait_ticks(1);
    press();
    checks++; if (bus.reel_run !== 3'b111) $display("FAIL min_spin_ignore got=%b exp=111", bus.reel_run); else passes++;
    while (tk - t0 < 3) step();
    checks++; if (bus.reel_run !== 3'b111) $display("FAIL min_spin_hold got=%b exp=111", bus.reel_run); else passes++;
    bus.start_but = 1'b1;
    step(); step();
    checks++; if (bus.reel_run !== 3'b111) $display("FAIL stop_pre got=%b exp=111", bus.reel_run); else passes++;
    step();
    bus.start_but = 1'b0;
    checks++; if (bus.reel_run !== 3'b110) $display("FAIL stop_press got=%b exp=110", bus.reel_run); else passes++;
    t0 = tk; n = 0; pressed = 0; pc = 0;
    while (n < 400) begin
      step(); n++;
      t = tk - t0;
      if (t == 1 && !pressed) begin bus.start_but = 1'b1; pressed = 1; pc = n; end
      if (pressed && n == pc + 3) bus.start_but = 1'b0;
      if (t >= 2*SG + 1) break;
      exp = (t < SG) ? 3'b110 : (t < 2*SG) ? 3'b100 : 3'b000;
      checks++; if (bus.reel_run !== exp) $display("FAIL stopping_reel tick=%0d got=%b exp=%b", t, bus.reel_run, exp); else passes++;
    end
    if (n >= 400) begin checks++; $display("FAIL stopping_timeout ticks=%0d", tk - t0); end
    bus.start_but = 1'b0;
    step();
    checks++; if (bus.busy !== 1'b0) $display("FAIL stopping_idle got=%b exp=0", bus.busy); else passes++;
    checks++; if (bus.credits !== 7'd2) $display("FAIL stopping_credits got=%0d exp=2", bus.credits); else passes++;
  endtask

  task automatic test_win();
    int t0, s, n;
    logic exp_b;
    do_reset();
    set_reels(4'd7, 4'd7, 4'd7);
    press();
    t0 = tk; n = 0;
    while (tk - t0 < AS + 2*SG + 1 && n < 400) begin step(); n++; end
    checks++; if (bus.credits !== 7'd2) $display("FAIL eval_credits got=%0d exp=2", bus.credits); else passes++;
    step();
    checks++; if (bus.win !== 1'b1) $display("FAIL show_win got=%b exp=1", bus.win); else passes++;
    checks++; if (bus.credits !== 7'd12) $display("FAIL show_credits got=%0d exp=12", bus.credits); else passes++;
    checks++; if (bus.blink !== 1'b0) $display("FAIL show_blink0 got=%b exp=0", bus.blink); else passes++;
    t0 = tk; n = 0;
    while (n < 400) begin
      step(); n++;
      s = tk - t0;
      if (s >= FT) break;
      exp_b = ((s / BT) % 2) == 1;
      checks++; if (bus.win !== 1'b1) $display("FAIL show_win tick=%0d got=%b exp=1", s, bus.win); else passes++;
      checks++; if (bus.blink !== exp_b) $display("FAIL show_blink tick=%0d got=%b exp=%b", s, bus.blink, exp_b); else passes++;
    end
    if (n >= 400) begin checks++; $display("FAIL show_timeout ticks=%0d", tk - t0); end
    checks++; if (bus.win !== 1'b0) $display("FAIL show_end_win got=%b exp=0", bus.win); else passes++;
    checks++; if (bus.blink !== 1'b1) $display("FAIL show_end_blink got=%b exp=1", bus.blink); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL show_end_busy got=%b exp=0", bus.busy); else passes++;
  endtask

  task automatic test_saturate();
    repeat (7) play(4'd1, 4'd2, 4'd3);
    checks++; if (bus.credits !== 7'd5) $display("FAIL sat_losses got=%0d exp=5", bus.credits); else passes++;
    repeat (10) play(4'd7, 4'd7, 4'd7);
    checks++; if (bus.credits !== 7'd95) $display("FAIL sat_95 got=%0d exp=95", bus.credits); else passes++;
    play(4'd7, 4'd7, 4'd7);
    checks++; if (bus.credits !== 7'd99) $display("FAIL sat_clamp got=%0d exp=99", bus.credits); else passes++;
    play(4'd7, 4'd7, 4'd7);
    checks++; if (bus.credits !== 7'd99) $display("FAIL sat_at_max got=%0d exp=99", bus.credits); else passes++;
  endtask

  task automatic test_no_credit();
    do_reset();
    repeat (3) play(4'd1, 4'd2, 4'd3);
    checks++; if (bus.credits !== 7'd0) $display("FAIL drain_credits got=%0d exp=0", bus.credits); else passes++;
    bus.start_but = 1'b1;
    step(); step();
    checks++; if (bus.no_credit !== 1'b0) $display("FAIL nc_early got=%b exp=0", bus.no_credit); else passes++;
    step();
    checks++; if (bus.no_credit !== 1'b1) $display("FAIL nc_pulse got=%b exp=1", bus.no_credit); else passes++;
    checks++; if (bus.reel_run !== 3'b000) $display("FAIL nc_reel got=%b exp=000", bus.reel_run); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL nc_busy got=%b exp=0", bus.busy); else passes++;
    step();
    checks++; if (bus.no_credit !== 1'b0) $display("FAIL nc_one_cycle got=%b exp=0", bus.no_credit); else passes++;
    bus.start_but = 1'b0;
    checks++; if (bus.credits !== 7'd0) $display("FAIL nc_credits got=%0d exp=0", bus.credits); else passes++;
  endtask

  task automatic test_show_press();
    int g;
    do_reset();
    set_reels(4'd7, 4'd7, 4'd7);
    press();
    wait_ticks(MS + 1);
    press();
    g = 0;
    while (!bus.win && g < 400) begin step(); g++; end
    checks++; if (bus.win !== 1'b1) $display("FAIL sp_enter got=%b exp=1", bus.win); else passes++;
    checks++; if (bus.credits !== 7'd12) $display("FAIL sp_credits got=%0d exp=12", bus.credits); else passes++;
    bus.start_but = 1'b1;
    step(); step();
    checks++; if (bus.busy !== 1'b1) $display("FAIL sp_pre got=%b exp=1", bus.busy); else passes++;
    step();
    bus.start_but = 1'b0;
    checks++; if (bus.busy !== 1'b0) $display("FAIL sp_exit got=%b exp=0", bus.busy); else passes++;
    checks++; if (bus.blink !== 1'b1) $display("FAIL sp_blink got=%b exp=1", bus.blink); else passes++;
    repeat (8) step();
    checks++; if (bus.reel_run !== 3'b000) $display("FAIL sp_no_spin got=%b exp=000", bus.reel_run); else passes++;
    checks++; if (bus.credits !== 7'd12) $display("FAIL sp_consumed got=%0d exp=12", bus.credits); else passes++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_reels(4'd1, 4'd2, 4'd3);
    press();
    wait_ticks(MS + 1);
    press();
    wait_ticks(1);
    checks++; if (bus.reel_run !== 3'b110) $display("FAIL rm_stopping got=%b exp=110", bus.reel_run); else passes++;
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.reel_run !== 3'b000) $display("FAIL rm_reel got=%b exp=000", bus.reel_run); else passes++;
    checks++; if (bus.credits !== 7'd3) $display("FAIL rm_credits got=%0d exp=3", bus.credits); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL rm_busy got=%b exp=0", bus.busy); else passes++;
    @(posedge clk); #1 rst = 1'b1;
    tk = 0;
    repeat (6) step();
    checks++; if (bus.busy !== 1'b0) $display("FAIL rm_after got=%b exp=0", bus.busy); else passes++;
  endtask

  task automatic test_pair();
    int g;
    bit saw_win;
    logic [6:0] exp_c;
    do_reset();
    set_reels(4'd4, 4'd4, 4'd9);
    press();
    wait_ticks(MS + 1);
    press();
    g = 0; saw_win = 0;
    while (bus.busy && g < 400) begin step(); g++; if (bus.win) saw_win = 1; end
    checks++; if (saw_win !== 1'b0) $display("FAIL pair_win got=%b exp=0", saw_win); else passes++;
    exp_c = 7'(2 + PP);
    checks++; if (bus.credits !== exp_c) $display("FAIL pair_449 got=%0d exp=%0d", bus.credits, exp_c); else passes++;
    repeat (4) step();
    play(4'd9, 4'd4, 4'd9);
    exp_c = 7'(2 + PP - 1 + PP);
    checks++; if (bus.credits !== exp_c) $display("FAIL pair_949 got=%0d exp=%0d", bus.credits, exp_c); else passes++;
  endtask

  initial begin
    bus.start_but = 1'b0;
    set_reels(4'd0, 4'd0, 4'd0);
    test_reset();
    test_auto_stop();
    test_min_spin();
    test_win();
    test_saturate();
    test_no_credit();
    test_show_press();
    test_reset_mid();
    test_pair();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
